// File: rtl/memory_stage.sv
// MEM stage of an RV32I pipeline: EX/MEM register, req/ack data-memory access
// with lane alignment and load extension, branch resolution and writeback register.
module memory_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_from_execution,
  input  logic [31:0] alu_result_from_execution,
  input  logic        flag_zero_from_execution,
  input  logic [31:0] add_sum_from_execution,
  input  logic [31:0] read_data_2_from_execution,
  input  logic [4:0]  immed_11_7_from_execution,
  input  logic [2:0]  funct3,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        branch,
  input  logic        reg_write,
  output logic        stall_to_pipeline,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        pc_src_from_memory,
  output logic [31:0] branch_target_from_memory,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_fault,
  output logic        mem_fault
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_FAULT  = 2'd2;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // Size/sign encodings outside the RV32I load/store set, or misaligned lanes.
  function automatic logic f_illegal(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] a);
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = a[0];
      3'b010:  bad = (a != 2'b00);
      3'b100:  bad = is_store;
      3'b101:  bad = is_store | a[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_valid, r_zero, r_mem_read, r_mem_write, r_branch, r_reg_write;
  logic [31:0]   r_alu, r_add_sum, r_rs2;
  logic [4:0]    r_rd;
  logic [2:0]    r_f3;
  logic          r_wb_valid, r_wb_reg_write, r_misalign;
  logic [4:0]    r_wb_rd;
  logic [31:0]   r_wb_data;

  logic          w_access, w_capture, w_in_go, w_r_mem, w_r_illegal;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_shift, w_load;

  assign w_access    = (r_state == S_ACCESS);
  assign stall_to_pipeline = (w_access & ~dmem_ack) | (r_state == S_FAULT);
  assign w_capture   = ~stall_to_pipeline;
  // The access starts in the same edge that captures the op, so the first request cycle
  // is the first cycle the op sits in EX/MEM.
  assign w_in_go     = valid_from_execution & (mem_read | mem_write) &
                       ~f_illegal(mem_write, funct3, alu_result_from_execution[1:0]);
  assign w_r_mem     = r_mem_read | r_mem_write;
  assign w_r_illegal = f_illegal(r_mem_write, r_f3, r_alu[1:0]);

  // Store byte lanes and replicated write data.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = 32'h0000_0000;
    case (r_f3[1:0])
      2'b00:   begin w_be = 4'b0001 << r_alu[1:0];          w_wdata = {4{r_rs2[7:0]}};  end
      2'b01:   begin w_be = 4'b0011 << {r_alu[1], 1'b0};    w_wdata = {2{r_rs2[15:0]}}; end
      default: begin w_be = 4'b1111;                        w_wdata = r_rs2;            end
    endcase
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    w_shift = dmem_rdata >> {r_alu[1:0], 3'b000};
    case (r_f3)
      3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_load = {24'h00_0000, w_shift[7:0]};
      3'b101:  w_load = {16'h0000, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

  // Access FSM and timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= {CW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= w_in_go ? S_ACCESS : S_IDLE;
          r_cnt   <= {CW{1'b0}};
        end
        S_ACCESS: begin
          if (dmem_ack) begin
            r_state <= w_in_go ? S_ACCESS : S_IDLE;
            r_cnt   <= {CW{1'b0}};
          end else if (r_cnt == LAST_WAIT) begin
            r_state <= S_FAULT;
            r_cnt   <= {CW{1'b0}};
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;  r_zero <= 1'b0;  r_mem_read <= 1'b0;  r_mem_write <= 1'b0;
      r_branch <= 1'b0; r_reg_write <= 1'b0;
      r_alu <= 32'h0;   r_add_sum <= 32'h0; r_rs2 <= 32'h0;
      r_rd <= 5'd0;     r_f3 <= 3'd0;
    end else if (w_capture) begin
      r_valid     <= valid_from_execution;
      r_zero      <= flag_zero_from_execution;
      r_mem_read  <= mem_read;
      r_mem_write <= mem_write;
      r_branch    <= branch;
      r_reg_write <= reg_write;
      r_alu       <= alu_result_from_execution;
      r_add_sum   <= add_sum_from_execution;
      r_rs2       <= read_data_2_from_execution;
      r_rd        <= immed_11_7_from_execution;
      r_f3        <= funct3;
    end
  end

  // Writeback register: one strobe per retired instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_valid <= 1'b0; r_wb_reg_write <= 1'b0; r_misalign <= 1'b0;
      r_wb_rd <= 5'd0;    r_wb_data <= 32'h0;
    end else begin
      r_wb_valid <= 1'b0;
      r_misalign <= 1'b0;
      if ((r_state == S_IDLE) && r_valid && (~w_r_mem || w_r_illegal)) begin
        r_wb_valid     <= 1'b1;
        r_wb_rd        <= r_rd;
        r_wb_data      <= r_alu;
        r_wb_reg_write <= r_reg_write & ~w_r_mem;
        r_misalign     <= w_r_mem;
      end else if (w_access && dmem_ack) begin
        r_wb_valid     <= 1'b1;
        r_wb_rd        <= r_rd;
        r_wb_data      <= r_mem_read ? w_load : r_alu;
        r_wb_reg_write <= r_reg_write & ~r_mem_write;
      end
    end
  end

  assign dmem_req   = w_access;
  assign dmem_we    = w_access & r_mem_write;
  assign dmem_addr  = w_access ? {r_alu[31:2], 2'b00} : 32'h0;
  assign dmem_wdata = w_access ? w_wdata : 32'h0;
  assign dmem_be    = w_access ? w_be : 4'b0000;

  assign pc_src_from_memory        = r_valid & r_branch & r_zero;
  assign branch_target_from_memory = r_add_sum;

  assign wb_valid       = r_wb_valid;
  assign wb_reg_write   = r_wb_reg_write;
  assign wb_rd          = r_wb_rd;
  assign wb_data        = r_wb_data;
  assign misalign_fault = r_misalign;
  assign mem_fault      = (r_state == S_FAULT);
endmodule
